hazard_fwd_unit: RTL and testbench

Hazard and forwarding controller for the 5-stage pipeline. Tracks destination/write-enable records for instructions in EX, MEM and WB. Produces:
- the 2-bit `forwarda`/`forwardb` selects consumed by the EX-stage operand forwarding muxes;
- the load-use `stall` consumed by the PC and IF/ID registers.

It sits between decode (ID) and the EX operand muxes, mirroring the ID/EX → EX/MEM → MEM/WB pipeline registers for control purposes.

---
 rtl/pipe_pkg.sv | 50 +++++
 rtl/fwd_select.sv | 31 +++
 rtl/hazard_fwd_unit.sv | 109 ++++++++++
 tb/tb_hazard_fwd_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the 5-stage pipeline control path:
//   FWD_REG / FWD_WB / FWD_MEM : encodings of the EX operand forwarding
//                                mux selects (also used by the mux itself)
//   REG_ZERO                   : index of the hardwired-zero register
//   stage_rec_t                : full control record tracked for EX
//   wr_rec_t                   : reduced write-back record tracked for MEM/WB
//   rec_writes()               : does a write record produce a usable value
//                                for the given source register index
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Control record of the instruction currently in EX.
    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } stage_rec_t;

    // Once an instruction leaves EX only its register write matters:
    // memread is intentionally dropped, so a load in MEM never stalls.
    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic [REG_W-1:0] dst;
    } wr_rec_t;

    // A record can supply a source only if it is a live register write to
    // the same, nonzero index. $0 is never forwarded even if some record
    // claims to write it.
    function automatic logic rec_writes(input wr_rec_t rec,
                                        input logic [REG_W-1:0] src);
        return rec.valid && rec.regwrite &&
               (rec.dst != REG_ZERO) && (rec.dst == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
//
// Combinational forwarding select for one EX source operand.
//   src      in  5 : source register index of the EX instruction
//   mem_rec  in    : write record of the instruction in MEM
//   wb_rec   in    : write record of the instruction in WB
//   fwd_sel  out 2 : FWD_MEM, FWD_WB or FWD_REG (11 is never produced)
//
// MEM is checked first: it holds the younger of the two writers, so its
// result is the architecturally current value of the register.
// ---------------------------------------------------------------------------
module fwd_select
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  wr_rec_t          mem_rec,
    input  wr_rec_t          wb_rec,
    output logic [1:0]       fwd_sel
);

    always_comb begin
        fwd_sel = FWD_REG;
        if (rec_writes(mem_rec, src)) begin
            fwd_sel = FWD_MEM;
        end else if (rec_writes(wb_rec, src)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
//
// Hazard and forwarding controller for the 5-stage pipeline. Mirrors the
// ID/EX -> EX/MEM -> MEM/WB registers for control purposes only.
//
// Ports:
//   clk          in  1 : pipeline clock, rising edge
//   rst          in  1 : synchronous active-high reset, clears all records
//   rs_id        in  5 : rs field of the ID instruction
//   rt_id        in  5 : rt field of the ID instruction
//   dst_id       in  5 : destination of the ID instruction (after RegDst)
//   regwrite_id  in  1 : ID instruction writes the register file
//   memread_id   in  1 : ID instruction is a load
//   flush        in  1 : taken branch/jump, ID instruction must not enter EX
//   hold         in  1 : global freeze, no record advances
//   forwarda     out 2 : EX operand A select (vs EX.rs)
//   forwardb     out 2 : EX operand B select (vs EX.rt)
//   stall        out 1 : load-use hazard, hold PC and IF/ID, bubble into EX
//
// Interface contract (level-based, no handshake): forwarda/forwardb depend
// only on registered records, so they settle early in the cycle. stall
// additionally depends on rs_id/rt_id from the same cycle. hold takes
// precedence over stall and flush; while held those conditions are simply
// re-evaluated on the next unheld cycle.
// ---------------------------------------------------------------------------
module hazard_fwd_unit
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic [REG_W-1:0] dst_id,
    input  logic             regwrite_id,
    input  logic             memread_id,
    input  logic             flush,
    input  logic             hold,
    output logic [1:0]       forwarda,
    output logic [1:0]       forwardb,
    output logic             stall
);

    stage_rec_t ex_q,  ex_d;
    wr_rec_t    mem_q, mem_d;
    wr_rec_t    wb_q,  wb_d;
    logic       stall_c;

    // Load-use detection on raw rs/rt fields. An instruction that does not
    // actually read rt may see a false stall; that only costs one cycle.
    always_comb begin
        stall_c = ex_q.valid && ex_q.memread &&
                  (ex_q.dst != REG_ZERO) &&
                  ((ex_q.dst == rs_id) || (ex_q.dst == rt_id));
    end

    // Record advance. A stall and a flush both just turn the EX slot into a
    // bubble, so their coincidence is indistinguishable from flush alone.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!hold) begin
            if (stall_c || flush) begin
                ex_d = '0;
            end else begin
                ex_d.valid    = 1'b1;
                ex_d.regwrite = regwrite_id;
                ex_d.memread  = memread_id;
                ex_d.dst      = dst_id;
                ex_d.rs       = rs_id;
                ex_d.rt       = rt_id;
            end
            mem_d.valid    = ex_q.valid;
            mem_d.regwrite = ex_q.regwrite;
            mem_d.dst      = ex_q.dst;
            wb_d           = mem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    fwd_select u_fwd_a (
        .src     (ex_q.rs),
        .mem_rec (mem_q),
        .wb_rec  (wb_q),
        .fwd_sel (forwarda)
    );

    fwd_select u_fwd_b (
        .src     (ex_q.rt),
        .mem_rec (mem_q),
        .wb_rec  (wb_q),
        .fwd_sel (forwardb)
    );

    assign stall = stall_c;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_unit
//
// Directed instruction sequences. Each driven cycle pushes the hand-derived
// {stall, forwarda, forwardb} expected for that cycle; a monitor on the
// falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_unit;

    logic       clk;
    logic       rst;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic [4:0] dst_id;
    logic       regwrite_id;
    logic       memread_id;
    logic       flush;
    logic       hold;
    logic [1:0] forwarda;
    logic [1:0] forwardb;
    logic       stall;

    logic [4:0] exp_q[$];
    int         tag_q[$];
    int         n_checks;
    int         n_errors;
    int         n_issued;

    hazard_fwd_unit dut (
        .clk         (clk),
        .rst         (rst),
        .rs_id       (rs_id),
        .rt_id       (rt_id),
        .dst_id      (dst_id),
        .regwrite_id (regwrite_id),
        .memread_id  (memread_id),
        .flush       (flush),
        .hold        (hold),
        .forwarda    (forwarda),
        .forwardb    (forwardb),
        .stall       (stall)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver ----------------
    // Drives one cycle's ID inputs just after the rising edge and records
    // what the outputs must show during that cycle.
    task automatic drive(input logic r,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst,
                         input logic rw, input logic mr,
                         input logic fl, input logic hd,
                         input logic e_stall,
                         input logic [1:0] e_fa, input logic [1:0] e_fb);
        @(posedge clk);
        #1;
        rst         = r;
        rs_id       = rs;
        rt_id       = rt;
        dst_id      = dst;
        regwrite_id = rw;
        memread_id  = mr;
        flush       = fl;
        hold        = hd;
        n_issued++;
        exp_q.push_back({e_stall, e_fa, e_fb});
        tag_q.push_back(n_issued);
    endtask

    // Convenience: a nop in ID (no write, no sources), normal advance.
    task automatic drive_nop(input logic e_stall,
                             input logic [1:0] e_fa, input logic [1:0] e_fb);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
              e_stall, e_fa, e_fb);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [4:0] exp_v;
            int         tag;
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            n_checks++;
            if ({stall, forwarda, forwardb} !== exp_v) begin
                n_errors++;
                $display("FAIL cyc%0d stall/fa/fb: got %b/%b/%b want %b/%b/%b",
                         tag, stall, forwarda, forwardb,
                         exp_v[4], exp_v[3:2], exp_v[1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        n_issued = 0;
        rst = 1'b1; rs_id = '0; rt_id = '0; dst_id = '0;
        regwrite_id = 1'b0; memread_id = 1'b0; flush = 1'b0; hold = 1'b0;

        // Reset state: ID sources present but nothing may stall/forward.
        drive(1, 5'd3, 5'd3, 5'd3, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        drive(1, 5'd3, 5'd3, 5'd3, 1, 1, 0, 0, 0, 2'b00, 2'b00);

        // Back-to-back: add $3,$1,$2 ; sub $4,$3,$5
        drive(0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd3, 5'd5, 5'd4, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive_nop(0, 2'b10, 2'b00);

        // Two apart: add $3 ; nop ; or $6,$7,$3 -> fb=01
        drive(0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b00);
        drive(0, 5'd7, 5'd3, 5'd6, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b01);

        // MEM override: add $3 ; add $3 ; or $6,$7,$3 -> fb=10
        drive(0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd4, 5'd5, 5'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd7, 5'd3, 5'd6, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b10);

        // Load-use: lw $8,0($9) ; add $10,$8,$8 (held in ID one extra cycle)
        drive(0, 5'd9, 5'd8, 5'd8, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd8, 5'd8, 5'd10, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        drive(0, 5'd8, 5'd8, 5'd10, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive_nop(0, 2'b01, 2'b01);

        // $0 destination: add $0,$1,$2 ; add $4,$0,$0
        drive(0, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b00);
        // lw $0 ; add $5,$0,$0 -> no stall
        drive(0, 5'd9, 5'd0, 5'd0, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b00);

        // Flush: add $3 ; or $6,$3,$3 flushed in ID -> never forwards
        drive(0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd3, 5'd3, 5'd6, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b00);

        // Hold for 3 cycles while forwarda=10
        drive(0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd3, 5'd5, 5'd4, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 2'b10, 2'b00);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 2'b10, 2'b00);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 2'b10, 2'b00);
        drive_nop(0, 2'b10, 2'b00);
        drive_nop(0, 2'b00, 2'b00);

        // Hold during a load-use stall: stall persists until unheld
        drive(0, 5'd9, 5'd8, 5'd8, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd8, 5'd8, 5'd10, 1, 0, 0, 1, 1, 2'b00, 2'b00);
        drive(0, 5'd8, 5'd8, 5'd10, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        drive(0, 5'd8, 5'd8, 5'd10, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive_nop(0, 2'b01, 2'b01);

        // Simultaneous flush and stall: single bubble
        drive(0, 5'd9, 5'd8, 5'd8, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd8, 5'd3, 5'd10, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b00);

        // Reset mid-stream with add $3 in MEM and a lw $8 in ID
        drive(0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(0, 5'd3, 5'd3, 5'd6, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(1, 5'd9, 5'd8, 5'd8, 1, 1, 0, 0, 0, 2'b10, 2'b10);
        drive(0, 5'd8, 5'd3, 5'd0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        drive_nop(0, 2'b00, 2'b00);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        if (n_checks < n_issued) begin
            n_errors++;
            $display("FAIL check_count: got %0d want %0d", n_checks, n_issued);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
